// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared SoC bus definitions: arbiter FSM states, access-size codes, burst counter width.
package gpio_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      SizeWord = 2'b00,
      SizeHalf = 2'b01,
      SizeByte = 2'b10
   } mem_size_e;

   localparam int unsigned             BurstCntW   = 4;
   localparam logic [BurstCntW-1:0]    BurstCntMax = '1;

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// Two-master request/grant bundle plus the single-slave bus driven by the arbiter.
interface gpio_bus_arbiter_if;

   logic        m0_req,   m1_req;
   logic [31:0] m0_addr,  m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_write, m1_write;
   logic [1:0]  m0_size,  m1_size;
   logic        m0_lock,  m1_lock;
   logic        m0_gnt,   m1_gnt;
   logic        m0_done,  m1_done;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] bAddr, bWData;
   logic        bSel, bWrite;
   logic [1:0]  mem_size;
   logic [31:0] bRData;

   // Arbiter side: masters the slave bus, serves the request ports.
   modport master (
      input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
      input  m0_write, m1_write, m0_size, m1_size, m0_lock, m1_lock, bRData,
      output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
      output bAddr, bWData, bSel, bWrite, mem_size
   );

   // Environment side: requesting masters and the addressed slave.
   modport slave (
      output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
      output m0_write, m1_write, m0_size, m1_size, m0_lock, m1_lock, bRData,
      input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
      input  bAddr, bWData, bSel, bWrite, mem_size
   );

endinterface

// File: rtl/gpio_bus_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick with a bounded lock hold for the last owner.
module rr_arbiter2
   import gpio_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                 i_req0,
   input  logic                 i_req1,
   input  logic                 i_lock0,
   input  logic                 i_lock1,
   input  logic                 i_last_owner,
   input  logic [BurstCntW-1:0] i_burst_cnt,
   output logic                 o_vld,
   output logic                 o_pick
);

   localparam logic [BurstCntW-1:0] LockLimit = BurstCntW'(MAX_BURST - 1);

   logic w_last_req;
   logic w_last_lock;
   logic w_hold;

   assign w_last_req  = i_last_owner ? i_req1  : i_req0;
   assign w_last_lock = i_last_owner ? i_lock1 : i_lock0;
   // LockLimit of 0 (MAX_BURST=1) makes the hold unreachable.
   assign w_hold      = w_last_req && w_last_lock && (i_burst_cnt < LockLimit);

   assign o_vld = i_req0 || i_req1;

   always_comb begin
      o_pick = i_req1;
      if (w_hold) begin
         o_pick = i_last_owner;
      end else if (i_req0 && i_req1) begin
         o_pick = ~i_last_owner;
      end
   end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Two-master arbiter for a single slave: grant, one-cycle bus access, done pulse.
module gpio_bus_arbiter
   import gpio_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4
) (
   input logic                clk,
   input logic                rst,
   gpio_bus_arbiter_if.master bus
);

   arb_state_e           r_state, w_state_next;
   logic                 r_owner;
   logic [BurstCntW-1:0] r_burst_cnt, w_burst_next;
   logic [31:0]          r_addr, r_wdata;
   logic                 r_write;
   mem_size_e            r_size;
   logic [31:0]          r_m0_rdata, r_m1_rdata;

   logic        w_pick_vld, w_pick, w_grant, w_done, w_access;
   logic [31:0] w_sel_addr, w_sel_wdata;
   logic        w_sel_write, w_sel_lock;
   logic [1:0]  w_sel_size;

   rr_arbiter2 #(
      .MAX_BURST(MAX_BURST)
   ) u_rr (
      .i_req0      (bus.m0_req),
      .i_req1      (bus.m1_req),
      .i_lock0     (bus.m0_lock),
      .i_lock1     (bus.m1_lock),
      .i_last_owner(r_owner),
      .i_burst_cnt (r_burst_cnt),
      .o_vld       (w_pick_vld),
      .o_pick      (w_pick)
   );

   assign w_sel_addr  = w_pick ? bus.m1_addr  : bus.m0_addr;
   assign w_sel_wdata = w_pick ? bus.m1_wdata : bus.m0_wdata;
   assign w_sel_write = w_pick ? bus.m1_write : bus.m0_write;
   assign w_sel_size  = w_pick ? bus.m1_size  : bus.m0_size;
   assign w_sel_lock  = w_pick ? bus.m1_lock  : bus.m0_lock;

   // Pulses are masked while reset is held so an aborted cycle never reports.
   assign w_grant  = (r_state != StAccess) && !rst && w_pick_vld;
   assign w_done   = (r_state == StDone) && !rst;
   assign w_access = (r_state == StAccess);

   always_comb begin
      w_burst_next = '0;
      if ((w_pick == r_owner) && w_sel_lock) begin
         w_burst_next = (r_burst_cnt == BurstCntMax) ? r_burst_cnt : r_burst_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle, StDone: w_state_next = w_pick_vld ? StAccess : StIdle;
         StAccess:       w_state_next = StDone;
         default:        w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_owner     <= 1'b1;
         r_burst_cnt <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_write     <= 1'b0;
         r_size      <= SizeWord;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_grant) begin
            r_owner     <= w_pick;
            r_burst_cnt <= w_burst_next;
            r_addr      <= w_sel_addr;
            r_wdata     <= w_sel_wdata;
            r_write     <= w_sel_write;
            r_size      <= mem_size_e'(w_sel_size);
         end
         if (w_access && !r_write) begin
            if (r_owner) begin
               r_m1_rdata <= bus.bRData;
            end else begin
               r_m0_rdata <= bus.bRData;
            end
         end
      end
   end

   assign bus.m0_gnt   = w_grant && !w_pick;
   assign bus.m1_gnt   = w_grant && w_pick;
   assign bus.m0_done  = w_done && !r_owner;
   assign bus.m1_done  = w_done && r_owner;
   assign bus.m0_rdata = r_m0_rdata;
   assign bus.m1_rdata = r_m1_rdata;

   assign bus.bSel     = w_access;
   assign bus.bWrite   = w_access && r_write;
   assign bus.bAddr    = w_access ? r_addr  : '0;
   assign bus.bWData   = w_access ? r_wdata : '0;
   assign bus.mem_size = w_access ? r_size  : SizeWord;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed and randomized check of gpio_bus_arbiter against a grant-timeline model.
module tb_gpio_bus_arbiter;
   import gpio_bus_arbiter_pkg::*;

   localparam int MaxBurst = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   gpio_bus_arbiter_if bus_if ();

   gpio_bus_arbiter #(
      .MAX_BURST(MaxBurst)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Stimulus for the next cycle.
   logic        s_rst;
   logic        s_req   [2];
   logic        s_lock  [2];
   logic [31:0] s_addr  [2];
   logic [31:0] s_wdata [2];
   logic        s_write [2];
   logic [1:0]  s_size  [2];
   logic [31:0] s_rdata;

   // Reference model: a grant at cycle N puts its transfer on the bus at N+1
   // and reports done at N+2.
   logic        m_last;
   int          m_cnt;
   logic [31:0] m_rdata [2];
   bit          acc_vld;
   logic        acc_owner, acc_write;
   logic [31:0] acc_addr, acc_wdata;
   logic [1:0]  acc_size;
   bit          done_vld;
   logic        done_owner;
   int          grant_q[$];

   task automatic model_reset();
      m_last = 1'b1; m_cnt = 0;
      m_rdata[0] = '0; m_rdata[1] = '0;
      acc_vld = 0; done_vld = 0;
      acc_owner = 0; acc_write = 0; acc_addr = '0; acc_wdata = '0; acc_size = '0;
      done_owner = 0;
   endtask

   task automatic idle_inputs();
      s_rst = 0; s_rdata = '0;
      for (int i = 0; i < 2; i++) begin
         s_req[i] = 0; s_lock[i] = 0; s_addr[i] = '0; s_wdata[i] = '0;
         s_write[i] = 0; s_size[i] = 2'b00;
      end
   endtask

   task automatic step();
      logic       win;
      bit         gnt;
      logic [1:0] exp_gnt, exp_done;
      logic [67:0] exp_bus;
      @(posedge clk); #1;
      rst = s_rst;
      bus_if.m0_req = s_req[0];     bus_if.m1_req = s_req[1];
      bus_if.m0_lock = s_lock[0];   bus_if.m1_lock = s_lock[1];
      bus_if.m0_addr = s_addr[0];   bus_if.m1_addr = s_addr[1];
      bus_if.m0_wdata = s_wdata[0]; bus_if.m1_wdata = s_wdata[1];
      bus_if.m0_write = s_write[0]; bus_if.m1_write = s_write[1];
      bus_if.m0_size = s_size[0];   bus_if.m1_size = s_size[1];
      bus_if.bRData = s_rdata;
      @(negedge clk);
      gnt = 0; win = 0;
      if (!s_rst && !acc_vld && (s_req[0] || s_req[1])) begin
         gnt = 1;
         if (s_req[m_last] && s_lock[m_last] && (m_cnt < MaxBurst - 1)) win = m_last;
         else if (s_req[0] && s_req[1]) win = ~m_last;
         else win = s_req[1];
      end
      exp_gnt  = gnt ? (win ? 2'b10 : 2'b01) : 2'b00;
      exp_done = (done_vld && !s_rst) ? (done_owner ? 2'b10 : 2'b01) : 2'b00;
      exp_bus  = acc_vld ? {1'b1, acc_write, acc_size, acc_addr, acc_wdata} : '0;
      check_eq("gnt", {bus_if.m1_gnt, bus_if.m0_gnt}, exp_gnt);
      check_eq("done", {bus_if.m1_done, bus_if.m0_done}, exp_done);
      check_eq("bus", {bus_if.bSel, bus_if.bWrite, bus_if.mem_size, bus_if.bAddr, bus_if.bWData},
               exp_bus);
      check_eq("m0_rdata", bus_if.m0_rdata, m_rdata[0]);
      check_eq("m1_rdata", bus_if.m1_rdata, m_rdata[1]);
      if (s_rst) begin
         model_reset();
      end else begin
         if (acc_vld && !acc_write) m_rdata[acc_owner] = s_rdata;
         done_vld = acc_vld; done_owner = acc_owner;
         acc_vld = gnt;
         if (gnt) begin
            acc_owner = win; acc_addr = s_addr[win]; acc_wdata = s_wdata[win];
            acc_write = s_write[win]; acc_size = s_size[win];
            if (win == m_last && s_lock[win]) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            else m_cnt = 0;
            m_last = win;
            grant_q.push_back(int'(win));
         end
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      s_rst = 1; step(); step();
      s_rst = 0;
      grant_q.delete();
   endtask

   initial begin
      model_reset();
      idle_inputs();
      rst = 1'b1;
      bus_if.m0_req = 0; bus_if.m1_req = 0; bus_if.m0_lock = 0; bus_if.m1_lock = 0;
      bus_if.m0_addr = '0; bus_if.m1_addr = '0; bus_if.m0_wdata = '0; bus_if.m1_wdata = '0;
      bus_if.m0_write = 0; bus_if.m1_write = 0; bus_if.m0_size = '0; bus_if.m1_size = '0;
      bus_if.bRData = '0;

      // Single read by m0.
      do_reset();
      s_req[0] = 1; s_rdata = 32'h0000A5A5;
      step(); check_eq("rd_gnt", bus_if.m0_gnt, 1'b1);
      s_req[0] = 0;
      step(); check_eq("rd_bsel", bus_if.bSel, 1'b1);
      step(); check_eq("rd_done", bus_if.m0_done, 1'b1);
      check_eq("rd_rdata", bus_if.m0_rdata, 32'h0000A5A5);

      // Tie after reset alternates starting with m0.
      do_reset();
      s_req[0] = 1; s_req[1] = 1;
      repeat (8) step();
      check_eq("tie_cnt", grant_q.size(), 4);
      for (int i = 0; i < grant_q.size(); i++) check_eq("tie_owner", grant_q[i], i % 2);

      // Locked burst by m0 is cut after MaxBurst grants.
      do_reset();
      s_req[0] = 1; s_req[1] = 1; s_lock[0] = 1;
      repeat (10) step();
      check_eq("lock_cnt", grant_q.size(), 5);
      for (int i = 0; i < grant_q.size(); i++) check_eq("lock_owner", grant_q[i], (i == 4) ? 1 : 0);
      check_eq("burst_clr", dut.r_burst_cnt, 4'd0);

      // Write by m1.
      do_reset();
      s_req[1] = 1; s_write[1] = 1; s_addr[1] = 32'h4; s_wdata[1] = 32'h0000BEEF;
      s_rdata = 32'hDEADDEAD;
      step(); check_eq("wr_gnt", bus_if.m1_gnt, 1'b1);
      s_req[1] = 0;
      step();
      check_eq("wr_bus", {bus_if.bWrite, bus_if.bAddr, bus_if.bWData}, {1'b1, 32'h4, 32'h0000BEEF});
      step(); check_eq("wr_done", bus_if.m1_done, 1'b1);
      check_eq("wr_rdata", bus_if.m1_rdata, 32'h0);

      // Reset during ACCESS aborts the transfer.
      do_reset();
      s_req[0] = 1; s_req[1] = 1;
      step(); check_eq("abort_gnt", bus_if.m0_gnt, 1'b1);
      s_rst = 1; step();
      s_rst = 0; step();
      check_eq("abort_nodone", {bus_if.m1_done, bus_if.m0_done, bus_if.bSel}, 3'b000);
      check_eq("abort_tie", {bus_if.m1_gnt, bus_if.m0_gnt}, 2'b01);

      // Idle bus.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step();
         check_eq("idle", {bus_if.bSel, bus_if.m0_gnt, bus_if.m1_gnt, bus_if.m0_done,
                           bus_if.m1_done}, 5'b0);
      end

      // Randomized traffic with occasional resets.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         s_rst = ($urandom_range(0, 63) == 0);
         s_rdata = $urandom;
         for (int i = 0; i < 2; i++) begin
            s_req[i]   = ($urandom_range(0, 3) != 0);
            s_lock[i]  = ($urandom_range(0, 1) == 1);
            s_addr[i]  = $urandom;
            s_wdata[i] = $urandom;
            s_write[i] = $urandom_range(0, 1) == 1;
            s_size[i]  = 2'($urandom_range(0, 2));
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gpio_bus_arbiter.md
GPIO_BUS_ARBITER -- requirements
Module: gpio_bus_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive grants to one locked master; legal range 1..15.
REQ-002 Ports SHALL be as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  request, level.
- m0_addr / m1_addr  in  32  target address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_write / m1_write  in  1  1 = write, 0 = read.
- m0_size / m1_size  in  2  00 word, 01 half, 10 byte.
- m0_lock / m1_lock  in  1  request back-to-back ownership.
- m0_gnt / m1_gnt  out  1  one-cycle accept pulse.
- m0_done / m1_done  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  registered read data.
- bAddr, bWData  out  32  slave address and write data.
- bSel, bWrite  out  1  slave select and write.
- mem_size  out  2  slave access size.
- bRData  in  32  slave combinational read data.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-004 Arbitration SHALL occur only in IDLE and DONE; the winner's gnt SHALL pulse that cycle and its addr/wdata/write/size SHALL be latched, with next state ACCESS.
REQ-005 With no request in IDLE or DONE, next state SHALL be IDLE.
REQ-006 Each gnt SHALL consume exactly one transaction; the master presents its next request or deasserts req from the cycle after gnt.
REQ-007 In ACCESS, bSel SHALL be 1 for exactly one cycle and drive the latched fields; next state SHALL be DONE.
REQ-008 bSel, bWrite, bAddr, bWData and mem_size SHALL be 0 in every state except ACCESS.
REQ-009 On a read, bRData SHALL be captured into the owner's rdata at the end of ACCESS; on a write, rdata SHALL hold its value; the other master's rdata SHALL never change.
REQ-010 In DONE, the owner's done SHALL pulse for one cycle.
REQ-011 Latency SHALL be: gnt in cycle N, bSel in N+1, done and valid rdata in N+2; peak throughput one transaction per 2 cycles.
REQ-012 Default policy SHALL be two-way round-robin: with both requesting, the master not granted last wins; a single requester always wins.
REQ-013 Lock rule: if the last owner has req=1 and lock=1 and burst_cnt < MAX_BURST-1, that owner SHALL win regardless of round-robin.
REQ-014 burst_cnt (4 bits) SHALL increment on each grant to the same owner with lock=1, and clear to 0 on an owner change or a grant with lock=0.
REQ-015 When burst_cnt reaches MAX_BURST-1 and the other master requests, the other master SHALL win.
REQ-016 With MAX_BURST=1, lock SHALL have no effect.
REQ-017 At most one gnt and at most one done SHALL be high in any cycle.
REQ-018 Simultaneous arrival of both requests SHALL be resolved by REQ-012 in the same cycle.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE, last_owner=1 (so m0 wins the first tie), burst_cnt=0, both rdata=0, and all gnt, done and bus outputs 0 the following cycle.
REQ-020 Reset during ACCESS or DONE SHALL abort the transaction with no done pulse.
REQ-021 Reset SHALL hold for as long as rst=1.

Structure
REQ-022 The state encoding and mem_size encodings SHALL live in the shared SoC bus package.
REQ-023 The round-robin/lock decision SHALL be one sub-module, rr_arbiter2 (pure combinational pick plus last_owner input); the FSM and latches SHALL stay in gpio_bus_arbiter.

Verification
REQ-024 Single read: m0 reads 0x0, size 00, bRData=0x0000A5A5 -> m0_gnt at cycle N, bSel=1 at N+1, m0_done at N+2 with m0_rdata=0x0000A5A5.
REQ-025 Tie after reset: m0 and m1 both request continuously, lock=0 -> grants m0, m1, m0, m1 on a 2-cycle cadence.
REQ-026 Lock burst: MAX_BURST=4, m0 lock=1 and m1 requesting -> four m0 grants, then m1 granted; burst_cnt back at 0.
REQ-027 Write: m1 writes 0x4, wdata 0x0000BEEF -> bWrite=1, bAddr=0x4, bWData=0x0000BEEF for one cycle; m1_rdata unchanged; m1_done pulses.
REQ-028 Reset mid-op: rst=1 in the ACCESS cycle -> no done; bSel=0 the next cycle; the next tie goes to m0.
REQ-029 Idle bus: no requests for 10 cycles -> bSel and all gnt/done stay 0.
